regfile_wb_ctrl: RTL and testbench

Write-back controller on the initiator side of the integer register file's single write port (`we`/`waddr`/`wdata`). Accepts results from two producers, the ALU/CSR path and the LSU load return, over valid/ready handshakes. Serialises those results onto the one write port with starvation-bounded priority. Keeps a pending-destination scoreboard that decode queries to stall RAW hazards.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/wb_skid.sv | 49 ++++
 rtl/regfile_wb_ctrl.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file write-back path.
package regfile_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam int          REG_NUM    = 32;
    localparam logic [4:0]  ZERO_REG   = 5'd0;
    localparam int          WB_DATA_W  = 32;

    // Default-width write-back request; wider/narrower datapaths define their own.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/wb_skid.sv
// One-entry hold buffer: accepts a request on valid/ready and keeps it until taken.
module wb_skid
    import regfile_pkg::*;
#(
    parameter type req_t = wb_req_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  req_t in_req,
    input  logic take,
    output logic hv,
    output req_t hreq
);

    logic hv_q, hv_d;
    req_t hreq_q, hreq_d;

    // Handshake rule: a transfer happens on a rising edge where in_valid && in_ready.
    // The entry may be refilled in the same cycle it is taken.
    assign in_ready = !hv_q || take;

    always_comb begin
        hv_d   = hv_q;
        hreq_d = hreq_q;
        if (take) begin
            hv_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            hv_d   = 1'b1;
            hreq_d = in_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q   <= 1'b0;
            hreq_q <= '0;
        end else begin
            hv_q   <= hv_d;
            hreq_q <= hreq_d;
        end
    end

    assign hv   = hv_q;
    assign hreq = hreq_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Serialises ALU and LSU results onto the register file write port and tracks
// pending destinations so decode can stall on RAW hazards.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0]     lsu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  err
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } req_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic alu_hv, lsu_hv;
    req_t alu_hreq, lsu_hreq;
    logic grant_alu, grant_lsu, any_grant;
    req_t win;

    logic [3:0]                  alu_wait_q, alu_wait_d;
    logic                        we_q, we_d;
    logic [REG_ADDR_W-1:0]       waddr_q, waddr_d;
    logic [DATA_W-1:0]           wdata_q, wdata_d;
    logic [REG_NUM-1:0]          pend_q, pend_d;
    logic                        err_q, err_d;

    wb_skid #(.req_t(req_t)) u_alu_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_req   ({alu_rd, alu_data}),
        .take     (grant_alu),
        .hv       (alu_hv),
        .hreq     (alu_hreq)
    );

    wb_skid #(.req_t(req_t)) u_lsu_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (lsu_valid),
        .in_ready (lsu_ready),
        .in_req   ({lsu_rd, lsu_data}),
        .take     (grant_lsu),
        .hv       (lsu_hv),
        .hreq     (lsu_hreq)
    );

    // LSU wins by default; a waiting ALU result is forced through once it has lost STARVE_MAX times.
    always_comb begin
        grant_alu = alu_hv && (!lsu_hv || (alu_wait_q == STARVE_LIM));
        grant_lsu = lsu_hv && !grant_alu;
        any_grant = grant_alu || grant_lsu;
        win       = grant_alu ? alu_hreq : lsu_hreq;
    end

    always_comb begin
        alu_wait_d = alu_wait_q;
        if (!alu_hv || grant_alu) begin
            alu_wait_d = 4'd0;
        end else if (alu_wait_q != STARVE_LIM) begin
            alu_wait_d = alu_wait_q + 4'd1;
        end
    end

    always_comb begin
        we_d    = any_grant && (win.rd != ZERO_REG);
        waddr_d = any_grant ? win.rd : waddr_q;
        wdata_d = any_grant ? win.data : wdata_q;
    end

    // Set is applied after clear so a re-issued rd stays pending for its newer producer.
    always_comb begin
        pend_d = pend_q;
        if (we_q) begin
            pend_d[waddr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != ZERO_REG)) begin
            pend_d[issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q || (we_q && !pend_q[waddr_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_wait_q <= 4'd0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            pend_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            alu_wait_q <= alu_wait_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

    // The register file forwards a same-cycle write to its read ports, so the retiring rd is not busy.
    always_comb begin
        busy_rs1 = (chk_rs1 != ZERO_REG) && pend_q[chk_rs1] && !(we_q && (waddr_q == chk_rs1));
        busy_rs2 = (chk_rs2 != ZERO_REG) && pend_q[chk_rs2] && !(we_q && (waddr_q == chk_rs2));
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: write-port scoreboard plus point checks on busy/err/ready.
module tb_regfile_wb_ctrl;

    localparam int DATA_W = 32;
    localparam int W      = 5 + DATA_W;

    logic              clk;
    logic              rst_n;
    logic              alu_valid, alu_ready;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid, lsu_ready;
    logic [4:0]        lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              issue_valid;
    logic [4:0]        issue_rd;
    logic [4:0]        chk_rs1, chk_rs2;
    logic              busy_rs1, busy_rs2;
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              err;

    int vectors;
    int miscompares;
    logic [W-1:0] exp_q[$];
    int alu_low[4];

    regfile_wb_ctrl #(.DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .err         (err)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every write pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_we: got rd=%0d data=%h, want no write", waddr, wdata);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({waddr, wdata} !== e) begin
                    miscompares++;
                    $display("FAIL wb_write: got rd=%0d data=%h, want rd=%0d data=%h",
                             waddr, wdata, e[W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [DATA_W-1:0] d);
        exp_q.push_back({rd, d});
    endtask

    // Drivers start just after a rising edge and return just after the handshake edge.
    task automatic send_alu(input logic [4:0] rd, input logic [DATA_W-1:0] d, output int lows);
        logic hs;
        lows      = 0;
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            hs = alu_ready;
            if (!hs) lows++;
            tick();
            if (hs) break;
        end
        if (!hs) check("alu_handshake_timeout", 64'd0, 64'd1);
        alu_valid = 1'b0;
    endtask

    task automatic send_lsu(input logic [4:0] rd, input logic [DATA_W-1:0] d);
        logic hs;
        lsu_valid = 1'b1;
        lsu_rd    = rd;
        lsu_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            hs = lsu_ready;
            tick();
            if (hs) break;
        end
        if (!hs) check("lsu_handshake_timeout", 64'd0, 64'd1);
        lsu_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lows;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        chk_rs1     = '0;
        chk_rs2     = '0;

        // Reset state
        @(negedge clk);
        check("rst_we", 64'(we), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_alu_ready", 64'(alu_ready), 64'd1);
        check("rst_lsu_ready", 64'(lsu_ready), 64'd1);

        // Uncontended latency: handshake in cycle 0, write in cycle 2 only
        issue(5'd5);
        push_exp(5'd5, 32'h1234);
        send_alu(5'd5, 32'h1234, lows);
        @(negedge clk);
        check("lat_c1_we", 64'(we), 64'd0);
        @(negedge clk);
        check("lat_c2_we", 64'(we), 64'd1);
        check("lat_c2_waddr", 64'(waddr), 64'd5);
        @(negedge clk);
        check("lat_c3_we", 64'(we), 64'd0);
        tick();

        // RAW tracking on rd=7 through an LSU return
        issue(5'd7);
        chk_rs1 = 5'd7;
        @(negedge clk);
        check("busy7_issued", 64'(busy_rs1), 64'd1);
        tick();
        push_exp(5'd7, 32'hBEEF);
        send_lsu(5'd7, 32'hBEEF);
        @(negedge clk);
        check("busy7_inflight", 64'(busy_rs1), 64'd1);
        @(negedge clk);
        check("busy7_we_cycle_we", 64'(we), 64'd1);
        check("busy7_we_cycle", 64'(busy_rs1), 64'd0);
        @(negedge clk);
        check("busy7_after", 64'(busy_rs1), 64'd0);
        tick();

        // Contention: LSU rds 11..26, ALU rds 27..30; expected order L,L,L,L,A x4
        for (int r = 11; r <= 30; r++) issue(5'(r));
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) push_exp(5'(11 + 4*g + k), 32'hB000 + 32'(4*g + k));
            push_exp(5'(27 + g), 32'hA000 + 32'(g));
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int l;
                    send_alu(5'(27 + i), 32'hA000 + 32'(i), l);
                    alu_low[i] = l;
                end
            end
            begin
                for (int i = 0; i < 16; i++) send_lsu(5'(11 + i), 32'hB000 + 32'(i));
            end
        join
        drain("contention_drain");
        check("alu_blocked_0", 64'(alu_low[0]), 64'd0);
        check("alu_blocked_1", 64'(alu_low[1]), 64'd4);
        check("alu_blocked_2", 64'(alu_low[2]), 64'd4);
        check("alu_blocked_3", 64'(alu_low[3]), 64'd4);
        check("contention_err", 64'(err), 64'd0);

        // rd=0: consumed with no write, no pending bit, no error
        issue(5'd0);
        chk_rs1 = 5'd0;
        @(negedge clk);
        check("busy_x0", 64'(busy_rs1), 64'd0);
        tick();
        send_alu(5'd0, 32'h55, lows);
        repeat (4) tick();
        check("x0_ready", 64'(alu_ready), 64'd1);
        check("x0_err", 64'(err), 64'd0);

        // Retire rd=3 on the same edge as a new issue of rd=3: stays pending
        issue(5'd3);
        push_exp(5'd3, 32'h333);
        send_alu(5'd3, 32'h333, lows);
        tick();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        @(negedge clk);
        check("retire3_we", 64'(we), 64'd1);
        tick();
        issue_valid = 1'b0;
        chk_rs1     = 5'd3;
        @(negedge clk);
        check("set_wins", 64'(busy_rs1), 64'd1);
        check("retire3_err", 64'(err), 64'd0);
        tick();

        // Write to rd=9 with no pending bit raises sticky err
        push_exp(5'd9, 32'h999);
        send_lsu(5'd9, 32'h999);
        @(negedge clk);
        check("err_before", 64'(err), 64'd0);
        @(negedge clk);
        check("err_we_cycle", 64'(err), 64'd0);
        @(negedge clk);
        check("err_set", 64'(err), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);
        tick();
        drain("pre_reset_drain");

        // Asynchronous reset with both holds full: everything clears, nothing stale retires
        issue(5'd12);
        issue(5'd13);
        alu_valid = 1'b1;
        alu_rd    = 5'd12;
        alu_data  = 32'hDEAD;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd13;
        lsu_data  = 32'hCAFE;
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        chk_rs1   = 5'd12;
        chk_rs2   = 5'd13;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", 64'(we), 64'd0);
        check("arst_waddr", 64'(waddr), 64'd0);
        check("arst_wdata", 64'(wdata), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_busy1", 64'(busy_rs1), 64'd0);
        check("arst_busy2", 64'(busy_rs2), 64'd0);
        check("arst_alu_ready", 64'(alu_ready), 64'd1);
        check("arst_lsu_ready", 64'(lsu_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("post_rst_we", 64'(we), 64'd0);
        check("post_rst_queue", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
